// File: rtl/crash_detect_bonus.sv
// Pixel-level collision detector between my plane and the bullet-supply layer.
// Optional collected-bonus counter enabled by defining CRASH_BONUS_CNT_EN.
module crash_detect_bonus #(
    parameter int BONUS_NUM         = 4,
    parameter int BONUS_NUM_BIT_LEN = 2,
    parameter int OVL_THRESH        = 4,
    parameter int OVL_CNT_BIT_LEN   = 4,
    parameter int BONUS_CNT_BIT_LEN = 8
) (
    input  logic                         clk_vga,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic                         v_sync_i,
    input  logic                         me_alpha_i,
    input  logic                         bonus_alpha_i,
    input  logic [BONUS_NUM_BIT_LEN-1:0] bonus_idx_i,
    output logic                         crash_me_bonus_o,
    output logic [BONUS_NUM_BIT_LEN-1:0] crash_idx_o,
    output logic [BONUS_CNT_BIT_LEN-1:0] bonus_cnt_o
);

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_CLR  = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    localparam logic [OVL_CNT_BIT_LEN-1:0]   THRESH  = OVL_CNT_BIT_LEN'(OVL_THRESH);
    localparam logic [BONUS_NUM_BIT_LEN:0]   NUM_LIM = (BONUS_NUM_BIT_LEN + 1)'(BONUS_NUM);

    logic [1:0]                 state_q, state_d;
    logic                       v_sync_d_q;
    logic [OVL_CNT_BIT_LEN-1:0] cnt_q [BONUS_NUM];
    logic [OVL_CNT_BIT_LEN-1:0] cnt_d [BONUS_NUM];
    logic [BONUS_NUM-1:0]       hit_mask_q, hit_mask_d;
    logic                       crash_q, crash_d;
    logic [BONUS_NUM_BIT_LEN-1:0] crash_idx_q, crash_idx_d;

    logic                       vs_rise;
    logic                       idx_ok;
    logic                       overlap;
    logic                       hit;
    logic [OVL_CNT_BIT_LEN-1:0] cnt_inc;

    assign vs_rise = v_sync_i & ~v_sync_d_q;
    assign idx_ok  = ({1'b0, bonus_idx_i} < NUM_LIM);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hit_mask_d  = hit_mask_q;
        crash_idx_d = crash_idx_q;
        overlap     = 1'b0;
        hit         = 1'b0;
        cnt_inc     = '0;

        case (state_q)
            ST_WAIT: begin
                for (int i = 0; i < BONUS_NUM; i++) cnt_d[i] = '0;
                hit_mask_d = '0;
                if (en_i && vs_rise) state_d = ST_CLR;
            end
            ST_CLR: begin
                for (int i = 0; i < BONUS_NUM; i++) cnt_d[i] = '0;
                hit_mask_d = '0;
                state_d    = en_i ? ST_SCAN : ST_WAIT;
            end
            ST_SCAN: begin
                // Disable beats a frame edge, and a frame edge beats any same-cycle overlap.
                if (!en_i) begin
                    state_d = ST_WAIT;
                end else if (vs_rise) begin
                    state_d = ST_CLR;
                end else if (me_alpha_i && bonus_alpha_i && idx_ok
                             && !hit_mask_q[bonus_idx_i]) begin
                    overlap = 1'b1;
                    if (cnt_q[bonus_idx_i] != THRESH) begin
                        cnt_inc            = cnt_q[bonus_idx_i] + 1'b1;
                        cnt_d[bonus_idx_i] = cnt_inc;
                        if (cnt_inc == THRESH) begin
                            hit                     = 1'b1;
                            hit_mask_d[bonus_idx_i] = 1'b1;
                            crash_idx_d             = bonus_idx_i;
                        end
                    end
                end
            end
            default: state_d = ST_WAIT;
        endcase

        crash_d = hit;
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            v_sync_d_q  <= 1'b1;
            for (int i = 0; i < BONUS_NUM; i++) cnt_q[i] <= '0;
            hit_mask_q  <= '0;
            crash_q     <= 1'b0;
            crash_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            v_sync_d_q  <= v_sync_i;
            cnt_q       <= cnt_d;
            hit_mask_q  <= hit_mask_d;
            crash_q     <= crash_d;
            crash_idx_q <= crash_idx_d;
        end
    end

    assign crash_me_bonus_o = crash_q;
    assign crash_idx_o      = crash_idx_q;

`ifdef CRASH_BONUS_CNT_EN
    logic [BONUS_CNT_BIT_LEN-1:0] bonus_cnt_q, bonus_cnt_d;

    // Updates on the same edge the pulse rises, so count and pulse appear together.
    always_comb begin
        bonus_cnt_d = bonus_cnt_q;
        if (hit && (bonus_cnt_q != '1)) bonus_cnt_d = bonus_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_vga) begin
        if (rst) bonus_cnt_q <= '0;
        else     bonus_cnt_q <= bonus_cnt_d;
    end

    assign bonus_cnt_o = bonus_cnt_q;
`else
    assign bonus_cnt_o = '0;
`endif

endmodule

// File: tb/tb_crash_detect_bonus.sv
// Self-checking bench for crash_detect_bonus: a per-frame overlap model pushes
// expected hits (index + due cycle) to a queue; a negedge monitor pops them.
module tb_crash_detect_bonus;
  logic       clk_vga;
  logic       rst;
  logic       en_i;
  logic       v_sync_i;
  logic       me_alpha_i;
  logic       bonus_alpha_i;
  logic [1:0] bonus_idx_i;
  logic       crash_me_bonus_o;
  logic [1:0] crash_idx_o;
  logic [7:0] bonus_cnt_o;

  crash_detect_bonus dut (
    .clk_vga          (clk_vga),
    .rst              (rst),
    .en_i             (en_i),
    .v_sync_i         (v_sync_i),
    .me_alpha_i       (me_alpha_i),
    .bonus_alpha_i    (bonus_alpha_i),
    .bonus_idx_i      (bonus_idx_i),
    .crash_me_bonus_o (crash_me_bonus_o),
    .crash_idx_o      (crash_idx_o),
    .bonus_cnt_o      (bonus_cnt_o)
  );

  // clock / reset
  initial begin
    clk_vga = 1'b0;
    forever #5 clk_vga = ~clk_vga;
  end

  int cyc = 0;
  always @(posedge clk_vga) cyc <= cyc + 1;

  // scoreboard state
  logic [1:0] exp_q[$];
  int         due_q[$];
  int         checks = 0;
  int         errors = 0;
  int         n_pulse = 0;

  // reference model of one frame
  bit         armed = 0;
  int         mcnt[4];
  bit [3:0]   mmask = '0;
  logic [1:0] last_idx = '0;
  int         bcnt_exp = 0;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    mmask = '0;
  endtask

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  // one scan pixel, v_sync held high
  task automatic pixel(input bit me, input bit bo, input logic [1:0] idx);
    me_alpha_i    = me;
    bonus_alpha_i = bo;
    bonus_idx_i   = idx;
    v_sync_i      = 1'b1;
    if (armed && en_i && me && bo && !mmask[idx]) begin
      mcnt[idx]++;
      if (mcnt[idx] == 4) begin
        mmask[idx] = 1'b1;
        exp_q.push_back(idx);
        due_q.push_back(cyc + 1);
        last_idx = idx;
`ifdef CRASH_BONUS_CNT_EN
        if (bcnt_exp < 255) bcnt_exp++;
`endif
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pixel(1'b0, 1'b0, 2'd0);
  endtask

  // v_sync low then high; optional overlap on the rising cycle is dropped
  task automatic frame_start(input bit ovl_on_edge, input logic [1:0] idx);
    me_alpha_i = 1'b0; bonus_alpha_i = 1'b0; v_sync_i = 1'b0;
    tick();
    me_alpha_i = ovl_on_edge; bonus_alpha_i = ovl_on_edge; bonus_idx_i = idx;
    v_sync_i = 1'b1;
    tick();
    if (en_i) armed = 1;
    model_clear();
    me_alpha_i = 1'b0; bonus_alpha_i = 1'b0;
    tick();  // clear cycle
  endtask

  task automatic check_quiet(input string name);
    idle(3);
    checks++;
    if (crash_idx_o !== last_idx) begin
      errors++;
      $display("FAIL %s crash_idx got=%0d exp=%0d", name, crash_idx_o, last_idx);
    end
    checks++;
    if (bonus_cnt_o !== 8'(bcnt_exp)) begin
      errors++;
      $display("FAIL %s bonus_cnt got=%0d exp=%0d", name, bonus_cnt_o, bcnt_exp);
    end
  endtask

  task automatic check_pulses(input string name, input int exp_n);
    checks++;
    if (n_pulse != exp_n) begin
      errors++;
      $display("FAIL %s pulse_count got=%0d exp=%0d", name, n_pulse, exp_n);
    end
  endtask

  // monitor
  always @(negedge clk_vga) begin
    logic [1:0] e;
    int d;
    if (crash_me_bonus_o === 1'b1) begin
      n_pulse++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse idx=%0d cyc=%0d exp=no_pulse", crash_idx_o, cyc);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        if (crash_idx_o !== e || d != cyc) begin
          errors++;
          $display("FAIL pulse idx=%0d cyc=%0d exp_idx=%0d exp_cyc=%0d", crash_idx_o, cyc, e, d);
        end
      end
    end else if (crash_me_bonus_o !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL pulse_x got=%b exp=0/1", crash_me_bonus_o);
    end else if (due_q.size() > 0 && due_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse got=none exp_idx=%0d exp_cyc=%0d", exp_q[0], due_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
  end

  // tests
  task automatic test_reset();
    rst = 1'b1; en_i = 1'b0; v_sync_i = 1'b1;
    me_alpha_i = 1'b0; bonus_alpha_i = 1'b0; bonus_idx_i = '0;
    tick(); tick();
    checks++;
    if (crash_me_bonus_o !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", crash_me_bonus_o); end
    checks++;
    if (crash_idx_o !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", crash_idx_o); end
    checks++;
    if (bonus_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bonus_cnt_o); end
    rst = 1'b0;
    armed = 0; model_clear(); last_idx = '0; bcnt_exp = 0;
    tick();
  endtask

  task automatic test_basic();
    int n0 = n_pulse;
    en_i = 1'b1;
    frame_start(1'b0, 2'd0);
    for (int i = 0; i < 4; i++) pixel(1'b1, 1'b1, 2'd2);
    check_quiet("basic");
    check_pulses("basic", n0 + 1);
  endtask

  task automatic test_frame_clear();
    int n0 = n_pulse;
    frame_start(1'b0, 2'd0);
    for (int i = 0; i < 3; i++) pixel(1'b1, 1'b1, 2'd1);
    frame_start(1'b0, 2'd0);
    for (int i = 0; i < 3; i++) pixel(1'b1, 1'b1, 2'd1);
    check_quiet("frame_clear");
    check_pulses("frame_clear", n0);
  endtask

  task automatic test_saturate();
    int n0 = n_pulse;
    frame_start(1'b0, 2'd0);
    for (int i = 0; i < 10; i++) pixel(1'b1, 1'b1, 2'd0);
    check_quiet("saturate_f1");
    check_pulses("saturate_f1", n0 + 1);
    frame_start(1'b0, 2'd0);
    for (int i = 0; i < 4; i++) pixel(1'b1, 1'b1, 2'd0);
    check_quiet("saturate_f2");
    check_pulses("saturate_f2", n0 + 2);
  endtask

  task automatic test_back_to_back();
    int n0 = n_pulse;
    frame_start(1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      pixel(1'b1, 1'b1, 2'd0);
      pixel(1'b1, 1'b1, 2'd3);
    end
    check_quiet("back_to_back");
    check_pulses("back_to_back", n0 + 2);
  endtask

  task automatic test_en_drop();
    int n0 = n_pulse;
    frame_start(1'b0, 2'd0);
    pixel(1'b1, 1'b1, 2'd1);
    pixel(1'b1, 1'b1, 2'd1);
    en_i = 1'b0; armed = 0;
    idle(2);
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) pixel(1'b1, 1'b1, 2'd1);
    check_quiet("en_drop_frame");
    check_pulses("en_drop_frame", n0);
    frame_start(1'b0, 2'd0);
    for (int i = 0; i < 4; i++) pixel(1'b1, 1'b1, 2'd1);
    check_quiet("en_drop_next");
    check_pulses("en_drop_next", n0 + 1);
  endtask

  task automatic test_edge_overlap();
    int n0 = n_pulse;
    frame_start(1'b0, 2'd0);
    for (int i = 0; i < 3; i++) pixel(1'b1, 1'b1, 2'd2);
    frame_start(1'b1, 2'd2);
    for (int i = 0; i < 3; i++) pixel(1'b1, 1'b1, 2'd2);
    check_quiet("edge_overlap");
    check_pulses("edge_overlap", n0);
  endtask

  task automatic test_reset_mid();
    int n0 = n_pulse;
    frame_start(1'b0, 2'd0);
    for (int i = 0; i < 3; i++) pixel(1'b1, 1'b1, 2'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    armed = 0; model_clear(); last_idx = '0; bcnt_exp = 0;
    for (int i = 0; i < 4; i++) pixel(1'b1, 1'b1, 2'd3);
    check_quiet("reset_mid");
    check_pulses("reset_mid", n0);
    frame_start(1'b0, 2'd0);
    for (int i = 0; i < 4; i++) pixel(1'b1, 1'b1, 2'd3);
    check_quiet("reset_mid_next");
    check_pulses("reset_mid_next", n0 + 1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      frame_start(1'b0, 2'd0);
      for (int i = 0; i < 40; i++)
        pixel(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    check_quiet("random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_clear();
    test_saturate();
    test_back_to_back();
    test_en_drop();
    test_edge_overlap();
    test_reset_mid();
    test_random();
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
